vga_fetch: RTL

Frame-buffer read initiator for the VGA port of the SRAM arbiter. It issues sequential 48-bit word reads over the arbiter's sel/addr/valid handshake, starting from a programmable base address. Returned words go into a show-ahead FIFO that the pixel pipeline drains at its own pace. It stops requesting when the FIFO is full or the frame is complete, and restarts on each frame-start pulse.

---
 rtl/vga_fetch_if.sv | 9 +
 rtl/vga_fetch.sv | 101 ++++++++++
 2 files changed

// File: rtl/vga_fetch_if.sv
// vga_fetch_if: sel/addr/valid read handshake between a fetch initiator and the SRAM arbiter
interface vga_fetch_if;
  logic [19:0] mem_addr;
  logic        mem_sel;
  logic [47:0] mem_data;
  logic        mem_valid;
  modport master(output mem_addr, mem_sel, input mem_data, mem_valid);
  modport slave(input mem_addr, mem_sel, output mem_data, mem_valid);
endinterface

// File: rtl/vga_fetch.sv
// vga_fetch: frame-buffer read initiator with show-ahead FIFO; VGA_FETCH_STATS_EN adds underflow/stall counters
module vga_fetch #(
  parameter int DEPTH       = 16,
  parameter int FRAME_WORDS = 76800
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [19:0]              base_addr,
  input  logic                     frame_start,
  vga_fetch_if.master              mem,
  input  logic                     pop,
  output logic [47:0]              data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     done_o,
  output logic                     underflow_o
`ifdef VGA_FETCH_STATS_EN
  ,
  output logic [15:0]              underflow_cnt,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, WAIT_SPACE = 2'd2, DONE = 2'd3;
  logic [1:0]    state, state_nxt;
  logic [47:0]   fifo [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level, level_nxt;
  logic [CW-1:0] count;
  logic [19:0]   addr;
  logic          push, pop_ok, last, uf;
  // accepted-word / dequeue decode and next-state selection; frame_start overrides everything
  always_comb begin
    push      = state == FETCH && mem.mem_valid && !frame_start;
    pop_ok    = pop && level != '0;
    level_nxt = level + (AW+1)'(push) - (AW+1)'(pop_ok);
    last      = count == CW'(FRAME_WORDS - 1);
    state_nxt = frame_start ? FETCH :
                state == FETCH ? (!mem.mem_valid ? FETCH : last ? DONE : level_nxt == FULL ? WAIT_SPACE : FETCH) :
                state == WAIT_SPACE ? (level < FULL ? FETCH : WAIT_SPACE) : state;
  end
  // control state, request address, frame word count and sticky underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      count <= '0;
      uf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        addr  <= base_addr;
        count <= '0;
        uf    <= 1'b0;
      end else begin
        if (push) begin
          addr  <= addr + 20'd1;
          count <= count + CW'(1);
        end
        if (pop && level == '0) uf <= 1'b1;
      end
    end
  end
  // FIFO pointers and occupancy; flushed by frame_start
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end
  // FIFO storage; contents are don't-care while unoccupied so no reset is needed
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem.mem_data;
  end
`ifdef VGA_FETCH_STATS_EN
  // saturating counters for empty pops and cycles parked waiting for FIFO space
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      underflow_cnt <= '0;
      stall_cnt     <= '0;
    end else begin
      if (pop && level == '0 && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      if (state == WAIT_SPACE && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
  assign mem.mem_sel  = state == FETCH;
  assign mem.mem_addr = addr;
  assign empty_o      = level == '0;
  assign data_o       = empty_o ? 48'h0 : fifo[rd_ptr];
  assign level_o      = level;
  assign done_o       = state == DONE;
  assign underflow_o  = uf;
endmodule
